// File: rtl/rob_rename_unit.sv
// Reorder buffer with a register-rename table, NUM_CPL completion channels
// and in-order single commit. Issue-time operand lookup returns either a
// value (register file, stored result or same-cycle completion bypass) or
// the producer tag. A commit whose actual next PC differs from the predicted
// one raises flush and empties the whole buffer at that edge.
//
// Entry state | meaning
// ST_EMPTY    | slot free
// ST_ISSUED   | instruction accepted, waiting for its result
// ST_DONE     | result and actual next PC captured, waiting to commit
module rob_rename_unit #(
    parameter int DEPTH_BITS = 3,
    parameter int NUM_CPL    = 2,
    parameter int XLEN       = 32
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic                             rdy_in,
    input  logic                             issue_valid,
    output logic                             issue_ready,
    output logic [DEPTH_BITS-1:0]            issue_tag,
    input  logic [4:0]                       issue_rd,
    input  logic [4:0]                       issue_rs1,
    input  logic [4:0]                       issue_rs2,
    input  logic [XLEN-1:0]                  issue_pred_pc,
    input  logic                             issue_is_store,
    input  logic [XLEN-1:0]                  rf_rs1_val,
    input  logic [XLEN-1:0]                  rf_rs2_val,
    output logic                             rs1_ready,
    output logic                             rs2_ready,
    output logic [XLEN-1:0]                  rs1_val,
    output logic [XLEN-1:0]                  rs2_val,
    output logic [DEPTH_BITS-1:0]            rs1_tag,
    output logic [DEPTH_BITS-1:0]            rs2_tag,
    input  logic [NUM_CPL-1:0]               cpl_valid,
    input  logic [NUM_CPL*DEPTH_BITS-1:0]    cpl_tag,
    input  logic [NUM_CPL*XLEN-1:0]          cpl_val,
    input  logic [NUM_CPL*XLEN-1:0]          cpl_next_pc,
    output logic [DEPTH_BITS-1:0]            head_tag,
    output logic                             head_is_store,
    output logic                             rf_we,
    output logic [4:0]                       rf_rd,
    output logic [XLEN-1:0]                  rf_wdata,
    output logic                             flush,
    output logic [XLEN-1:0]                  flush_pc
);

    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam int NREG  = 32;
    localparam logic [DEPTH_BITS:0] DEPTH_CNT = (DEPTH_BITS+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_ISSUED = 2'd1,
        ST_DONE   = 2'd2
    } ent_st_e;

    logic [DEPTH_BITS-1:0] head_q, head_d, tail_q, tail_d;
    logic [DEPTH_BITS:0]   count_q, count_d;

    ent_st_e               st_q    [DEPTH];
    ent_st_e               st_d    [DEPTH];
    logic [4:0]            rd_q    [DEPTH];
    logic [4:0]            rd_d    [DEPTH];
    logic [XLEN-1:0]       pred_q  [DEPTH];
    logic [XLEN-1:0]       pred_d  [DEPTH];
    logic [XLEN-1:0]       val_q   [DEPTH];
    logic [XLEN-1:0]       val_d   [DEPTH];
    logic [XLEN-1:0]       npc_q   [DEPTH];
    logic [XLEN-1:0]       npc_d   [DEPTH];
    logic                  store_q [DEPTH];
    logic                  store_d [DEPTH];

    logic [NREG-1:0]       busy_q, busy_d;
    logic [DEPTH_BITS-1:0] rtag_q  [NREG];
    logic [DEPTH_BITS-1:0] rtag_d  [NREG];

    logic [DEPTH_BITS-1:0] c_tag   [NUM_CPL];
    logic [XLEN-1:0]       c_val   [NUM_CPL];
    logic [XLEN-1:0]       c_npc   [NUM_CPL];

    logic                  hit     [DEPTH];
    logic [XLEN-1:0]       hit_val [DEPTH];
    logic [XLEN-1:0]       hit_npc [DEPTH];

    logic [4:0]            op_reg  [2];
    logic [XLEN-1:0]       op_rf   [2];
    logic                  op_rdy  [2];
    logic [XLEN-1:0]       op_val  [2];
    logic [DEPTH_BITS-1:0] op_tag  [2];

    logic issue_acc;
    logic commit;
    logic mispredict;

    // Unpack the flattened completion buses into per-channel views.
    always_comb begin
        for (int k = 0; k < NUM_CPL; k++) begin
            c_tag[k] = cpl_tag[k*DEPTH_BITS +: DEPTH_BITS];
            c_val[k] = cpl_val[k*XLEN +: XLEN];
            c_npc[k] = cpl_next_pc[k*XLEN +: XLEN];
        end
    end

    // Per-entry completion match; scanning high to low lets the lowest channel win.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            hit[i]     = 1'b0;
            hit_val[i] = '0;
            hit_npc[i] = '0;
            for (int k = NUM_CPL-1; k >= 0; k--) begin
                if (cpl_valid[k] && c_tag[k] == DEPTH_BITS'(i)) begin
                    hit[i]     = 1'b1;
                    hit_val[i] = c_val[k];
                    hit_npc[i] = c_npc[k];
                end
            end
        end
    end

    assign issue_ready   = (count_q < DEPTH_CNT);
    assign issue_tag     = tail_q;
    assign head_tag      = head_q;
    assign head_is_store = (st_q[head_q] == ST_ISSUED) && store_q[head_q];

    assign commit     = rdy_in && (count_q != '0) && (st_q[head_q] == ST_DONE);
    assign mispredict = commit && (npc_q[head_q] != pred_q[head_q]);
    assign issue_acc  = issue_valid && issue_ready && !mispredict && rdy_in;

    assign rf_we    = commit && (rd_q[head_q] != 5'd0);
    assign rf_rd    = rd_q[head_q];
    assign rf_wdata = val_q[head_q];
    assign flush    = mispredict;
    assign flush_pc = mispredict ? npc_q[head_q] : '0;

    assign op_reg[0] = issue_rs1;
    assign op_reg[1] = issue_rs2;
    assign op_rf[0]  = rf_rs1_val;
    assign op_rf[1]  = rf_rs2_val;

    // Operand lookup: not renamed, then stored result, then completion bypass.
    always_comb begin
        for (int o = 0; o < 2; o++) begin
            op_rdy[o] = 1'b1;
            op_val[o] = op_rf[o];
            op_tag[o] = rtag_q[op_reg[o]];
            if (op_reg[o] != 5'd0 && busy_q[op_reg[o]]) begin
                if (st_q[op_tag[o]] == ST_DONE) begin
                    op_val[o] = val_q[op_tag[o]];
                end else begin
                    op_rdy[o] = 1'b0;
                    op_val[o] = '0;
                    for (int k = NUM_CPL-1; k >= 0; k--) begin
                        if (cpl_valid[k] && c_tag[k] == op_tag[o]) begin
                            op_rdy[o] = 1'b1;
                            op_val[o] = c_val[k];
                        end
                    end
                end
            end
        end
    end

    assign rs1_ready = op_rdy[0];
    assign rs1_val   = op_val[0];
    assign rs1_tag   = op_tag[0];
    assign rs2_ready = op_rdy[1];
    assign rs2_val   = op_val[1];
    assign rs2_tag   = op_tag[1];

    // Next state: completion, commit, issue, then a mispredict overrides everything.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        busy_d  = busy_q;
        for (int i = 0; i < DEPTH; i++) begin
            st_d[i]    = st_q[i];
            rd_d[i]    = rd_q[i];
            pred_d[i]  = pred_q[i];
            val_d[i]   = val_q[i];
            npc_d[i]   = npc_q[i];
            store_d[i] = store_q[i];
        end
        for (int r = 0; r < NREG; r++) begin
            rtag_d[r] = rtag_q[r];
        end

        if (rdy_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (hit[i] && st_q[i] == ST_ISSUED) begin
                    st_d[i]  = ST_DONE;
                    val_d[i] = hit_val[i];
                    npc_d[i] = hit_npc[i];
                end
            end

            if (commit) begin
                st_d[head_q] = ST_EMPTY;
                head_d       = head_q + DEPTH_BITS'(1);
                // A newer producer (registered or arriving now) keeps the mapping alive.
                if (rd_q[head_q] != 5'd0 && rtag_q[rd_q[head_q]] == head_q &&
                    !(issue_acc && issue_rd == rd_q[head_q])) begin
                    busy_d[rd_q[head_q]] = 1'b0;
                end
            end

            if (issue_acc) begin
                st_d[tail_q]    = ST_ISSUED;
                rd_d[tail_q]    = issue_rd;
                pred_d[tail_q]  = issue_pred_pc;
                store_d[tail_q] = issue_is_store;
                val_d[tail_q]   = '0;
                npc_d[tail_q]   = '0;
                tail_d          = tail_q + DEPTH_BITS'(1);
                if (issue_rd != 5'd0) begin
                    busy_d[issue_rd] = 1'b1;
                    rtag_d[issue_rd] = tail_q;
                end
            end

            if (issue_acc && !commit) begin
                count_d = count_q + (DEPTH_BITS+1)'(1);
            end else if (!issue_acc && commit) begin
                count_d = count_q - (DEPTH_BITS+1)'(1);
            end

            if (mispredict) begin
                for (int i = 0; i < DEPTH; i++) begin
                    st_d[i] = ST_EMPTY;
                end
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
                busy_d  = '0;
            end
        end
    end

    // State registers; reset discards every in-flight entry.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            busy_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                st_q[i]    <= ST_EMPTY;
                rd_q[i]    <= '0;
                pred_q[i]  <= '0;
                val_q[i]   <= '0;
                npc_q[i]   <= '0;
                store_q[i] <= 1'b0;
            end
            for (int r = 0; r < NREG; r++) begin
                rtag_q[r] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            for (int i = 0; i < DEPTH; i++) begin
                st_q[i]    <= st_d[i];
                rd_q[i]    <= rd_d[i];
                pred_q[i]  <= pred_d[i];
                val_q[i]   <= val_d[i];
                npc_q[i]   <= npc_d[i];
                store_q[i] <= store_d[i];
            end
            for (int r = 0; r < NREG; r++) begin
                rtag_q[r] <= rtag_d[r];
            end
        end
    end

endmodule

// File: tb/tb_rob_rename_unit.sv
// Directed bench for rob_rename_unit. Expected commits go into a scoreboard
// queue when their completion is presented; a negedge monitor pops and
// compares whenever the DUT writes the register file or flushes.
// Issue-time lookups and status outputs are checked directly.
module tb_rob_rename_unit;

    localparam int DB = 3;
    localparam int NC = 2;
    localparam int XL = 32;

    logic              clk_in = 1'b0;
    logic              rst_in = 1'b1;
    logic              rdy_in = 1'b1;
    logic              issue_valid = 1'b0;
    logic              issue_ready;
    logic [DB-1:0]     issue_tag;
    logic [4:0]        issue_rd = '0, issue_rs1 = '0, issue_rs2 = '0;
    logic [XL-1:0]     issue_pred_pc = '0;
    logic              issue_is_store = 1'b0;
    logic [XL-1:0]     rf_rs1_val = '0, rf_rs2_val = '0;
    logic              rs1_ready, rs2_ready;
    logic [XL-1:0]     rs1_val, rs2_val;
    logic [DB-1:0]     rs1_tag, rs2_tag;
    logic [NC-1:0]     cpl_valid = '0;
    logic [NC*DB-1:0]  cpl_tag = '0;
    logic [NC*XL-1:0]  cpl_val = '0;
    logic [NC*XL-1:0]  cpl_next_pc = '0;
    logic [DB-1:0]     head_tag;
    logic              head_is_store;
    logic              rf_we;
    logic [4:0]        rf_rd;
    logic [XL-1:0]     rf_wdata;
    logic              flush;
    logic [XL-1:0]     flush_pc;

    rob_rename_unit #(.DEPTH_BITS(DB), .NUM_CPL(NC), .XLEN(XL)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_tag(issue_tag),
        .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_pred_pc(issue_pred_pc), .issue_is_store(issue_is_store),
        .rf_rs1_val(rf_rs1_val), .rf_rs2_val(rf_rs2_val),
        .rs1_ready(rs1_ready), .rs2_ready(rs2_ready),
        .rs1_val(rs1_val), .rs2_val(rs2_val),
        .rs1_tag(rs1_tag), .rs2_tag(rs2_tag),
        .cpl_valid(cpl_valid), .cpl_tag(cpl_tag), .cpl_val(cpl_val),
        .cpl_next_pc(cpl_next_pc),
        .head_tag(head_tag), .head_is_store(head_is_store),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .flush(flush), .flush_pc(flush_pc)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [4:0]    rd;
        logic [XL-1:0] wdata;
        logic          fl;
        logic [XL-1:0] fpc;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [XL-1:0] act, input logic [XL-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [4:0] rd, input logic [XL-1:0] wd,
                        input logic fl, input logic [XL-1:0] fpc);
        exp_t e;
        e.rd = rd; e.wdata = wd; e.fl = fl; e.fpc = fpc;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [XL-1:0] ppc, input logic st);
        issue_valid    = 1'b1;
        issue_rd       = rd;
        issue_rs1      = rs1;
        issue_rs2      = rs2;
        issue_pred_pc  = ppc;
        issue_is_store = st;
    endtask

    task automatic set_cpl(input int ch, input logic [DB-1:0] t,
                           input logic [XL-1:0] v, input logic [XL-1:0] n);
        cpl_valid[ch]            = 1'b1;
        cpl_tag[ch*DB +: DB]     = t;
        cpl_val[ch*XL +: XL]     = v;
        cpl_next_pc[ch*XL +: XL] = n;
    endtask

    task automatic idle();
        issue_valid    = 1'b0;
        issue_rd       = '0;
        issue_rs1      = '0;
        issue_rs2      = '0;
        issue_pred_pc  = '0;
        issue_is_store = 1'b0;
        cpl_valid      = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        #1;
    endtask

    task automatic chk_reset_outs(input string tagname);
        chk({tagname, "_issue_ready"}, issue_ready, 1);
        chk({tagname, "_issue_tag"}, issue_tag, 0);
        chk({tagname, "_head_tag"}, head_tag, 0);
        chk({tagname, "_head_is_store"}, head_is_store, 0);
        chk({tagname, "_rf_we"}, rf_we, 0);
        chk({tagname, "_flush"}, flush, 0);
        chk({tagname, "_flush_pc"}, flush_pc, 0);
    endtask

    // Commit monitor: every register write or flush must match the next expected commit.
    always @(negedge clk_in) begin
        exp_t e;
        if (!rst_in && rdy_in && (rf_we || flush)) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL commit_unexpected actual rd=%0d data=%0h flush=%0b required none",
                         rf_rd, rf_wdata, flush);
            end else begin
                e = sb_q.pop_front();
                chk("commit_we", rf_we, e.rd != 5'd0);
                chk("commit_rd", rf_rd, e.rd);
                chk("commit_wdata", rf_wdata, e.wdata);
                chk("commit_flush", flush, e.fl);
                chk("commit_flush_pc", flush_pc, e.fpc);
            end
        end
    end

    initial begin
        idle();
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        #1;
        chk_reset_outs("rst");

        // Fill all eight entries, then a refused ninth issue.
        for (int i = 0; i < 8; i++) begin
            issue(5'(i + 1), 5'd0, 5'd0, 32'h100 + 32'(4 * i), 1'b0);
            #1;
            chk("fill_tag", issue_tag, i);
            chk("fill_ready", issue_ready, 1);
            tick();
        end
        issue(5'd9, 5'd0, 5'd0, 32'h120, 1'b0);
        #1;
        chk("full_ready", issue_ready, 0);
        chk("full_tag", issue_tag, 0);
        tick();
        chk("full_ready_hold", issue_ready, 0);
        chk("full_head", head_tag, 0);
        issue_valid = 1'b0;
        set_cpl(0, 3'd0, 32'h11, 32'h100);
        push(5'd1, 32'h11, 1'b0, 32'h0);
        tick();
        cpl_valid = '0;
        chk("full_commit_cycle_ready", issue_ready, 0);
        tick();
        chk("after_commit_ready", issue_ready, 1);
        chk("after_commit_head", head_tag, 1);
        chk("after_commit_tail", issue_tag, 0);
        do_reset();

        // Producer tag, completion bypass, stored result, busy release.
        issue(5'd5, 5'd0, 5'd0, 32'h4, 1'b0);
        tick();
        issue(5'd6, 5'd5, 5'd0, 32'h8, 1'b0);
        rf_rs1_val = 32'hdead;
        rf_rs2_val = 32'h77;
        #1;
        chk("byp_rs1_ready_pre", rs1_ready, 0);
        chk("byp_rs1_tag_pre", rs1_tag, 0);
        chk("byp_rs1_val_pre", rs1_val, 0);
        chk("byp_rs2_ready", rs2_ready, 1);
        chk("byp_rs2_val", rs2_val, 32'h77);
        chk("byp_issue_tag", issue_tag, 1);
        set_cpl(1, 3'd0, 32'h1234, 32'h4);
        push(5'd5, 32'h1234, 1'b0, 32'h0);
        #1;
        chk("byp_rs1_ready", rs1_ready, 1);
        chk("byp_rs1_val", rs1_val, 32'h1234);
        tick();
        issue_valid = 1'b0;
        cpl_valid   = '0;
        issue_rs1   = 5'd5;
        issue_rs2   = 5'd6;
        #1;
        chk("done_rs1_ready", rs1_ready, 1);
        chk("done_rs1_val", rs1_val, 32'h1234);
        chk("pend_rs2_ready", rs2_ready, 0);
        chk("pend_rs2_tag", rs2_tag, 1);
        tick();
        chk("released_rs1_ready", rs1_ready, 1);
        chk("released_rs1_val", rs1_val, 32'hdead);
        chk("released_head", head_tag, 1);
        set_cpl(0, 3'd1, 32'h99, 32'h8);
        push(5'd6, 32'h99, 1'b0, 32'h0);
        tick();
        cpl_valid = '0;
        tick();
        chk("byp_end_head", head_tag, 2);
        do_reset();

        // Two renames of x3, then commit racing a third rename.
        rf_rs1_val = 32'h5555;
        issue(5'd3, 5'd0, 5'd0, 32'h10, 1'b0);
        tick();
        issue(5'd3, 5'd0, 5'd0, 32'h14, 1'b0);
        tick();
        issue_valid = 1'b0;
        set_cpl(0, 3'd0, 32'hA0, 32'h10);
        set_cpl(1, 3'd1, 32'hA1, 32'h14);
        push(5'd3, 32'hA0, 1'b0, 32'h0);
        push(5'd3, 32'hA1, 1'b0, 32'h0);
        tick();
        cpl_valid = '0;
        tick();
        issue(5'd3, 5'd3, 5'd0, 32'h18, 1'b0);
        #1;
        chk("x3_keep_ready", rs1_ready, 1);
        chk("x3_keep_val", rs1_val, 32'hA1);
        chk("x3_issue_tag", issue_tag, 2);
        tick();
        issue_valid = 1'b0;
        issue_rs1   = 5'd3;
        #1;
        chk("x3_newtag_ready", rs1_ready, 0);
        chk("x3_newtag_tag", rs1_tag, 2);
        chk("x3_head", head_tag, 2);

        // Both channels complete tag 2: channel 0 wins.
        set_cpl(0, 3'd2, 32'hA, 32'h18);
        set_cpl(1, 3'd2, 32'hB, 32'h18);
        push(5'd3, 32'hA, 1'b0, 32'h0);
        #1;
        chk("dup_bypass_ready", rs1_ready, 1);
        chk("dup_bypass_val", rs1_val, 32'hA);
        tick();
        cpl_valid = '0;
        #1;
        chk("dup_stored_val", rs1_val, 32'hA);
        tick();
        chk("dup_head", head_tag, 3);
        chk("dup_released_val", rs1_val, 32'h5555);
        do_reset();

        // Mispredicted branch at tag 0 with three younger entries in flight.
        issue(5'd7, 5'd0, 5'd0, 32'h104, 1'b0);
        tick();
        issue(5'd8, 5'd0, 5'd0, 32'h108, 1'b0);
        tick();
        issue(5'd9, 5'd0, 5'd0, 32'h10c, 1'b0);
        tick();
        issue(5'd10, 5'd0, 5'd0, 32'h110, 1'b1);
        tick();
        issue_valid = 1'b0;
        set_cpl(0, 3'd0, 32'h50, 32'h200);
        push(5'd7, 32'h50, 1'b1, 32'h200);
        tick();
        cpl_valid = '0;
        issue(5'd11, 5'd0, 5'd0, 32'h114, 1'b0);
        #1;
        chk("br_flush", flush, 1);
        chk("br_flush_pc", flush_pc, 32'h200);
        chk("br_rf_we", rf_we, 1);
        chk("br_issue_tag", issue_tag, 4);
        tick();
        issue_valid = 1'b0;
        issue_rs1   = 5'd8;
        issue_rs2   = 5'd11;
        rf_rs1_val  = 32'h3333;
        rf_rs2_val  = 32'h4444;
        #1;
        chk("post_flush_flush", flush, 0);
        chk("post_flush_head", head_tag, 0);
        chk("post_flush_tail", issue_tag, 0);
        chk("post_flush_ready", issue_ready, 1);
        chk("post_flush_rs1_ready", rs1_ready, 1);
        chk("post_flush_rs1_val", rs1_val, 32'h3333);
        chk("post_flush_rs2_ready", rs2_ready, 1);
        chk("post_flush_rs2_val", rs2_val, 32'h4444);
        set_cpl(0, 3'd1, 32'h66, 32'h108);
        tick();
        cpl_valid = '0;
        chk("stale_cpl_rf_we", rf_we, 0);
        chk("stale_cpl_head", head_tag, 0);
        do_reset();

        // Store at head, then rdy_in held low with a Done head.
        issue(5'd12, 5'd0, 5'd0, 32'h20, 1'b1);
        tick();
        issue(5'd13, 5'd0, 5'd0, 32'h24, 1'b0);
        #1;
        chk("store_head", head_is_store, 1);
        set_cpl(0, 3'd0, 32'h12, 32'h20);
        tick();
        rdy_in = 1'b0;
        issue(5'd14, 5'd0, 5'd0, 32'h28, 1'b0);
        cpl_valid = '0;
        set_cpl(1, 3'd1, 32'h77, 32'h24);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("frz_rf_we", rf_we, 0);
            chk("frz_head", head_tag, 0);
            chk("frz_tail", issue_tag, 2);
            chk("frz_store_done", head_is_store, 0);
            tick();
        end
        rdy_in = 1'b1;
        idle();
        issue_rs1 = 5'd13;
        push(5'd12, 32'h12, 1'b0, 32'h0);
        #1;
        chk("lost_cpl_ready", rs1_ready, 0);
        chk("lost_cpl_tag", rs1_tag, 1);
        tick();
        chk("thaw_head", head_tag, 1);
        set_cpl(0, 3'd1, 32'h77, 32'h24);
        push(5'd13, 32'h77, 1'b0, 32'h0);
        tick();
        cpl_valid = '0;
        issue(5'd14, 5'd0, 5'd0, 32'h28, 1'b0);
        tick();
        issue_valid = 1'b0;
        #1;
        chk("pre_rst_tail", issue_tag, 3);
        chk("pre_rst_head", head_tag, 2);
        rst_in = 1'b1;
        #1;
        chk_reset_outs("async_rst");
        tick();
        rst_in = 1'b0;
        tick();
        tick();
        chk("post_rst_rf_we", rf_we, 0);
        chk("sb_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
